regfile_32x32: RTL and testbench
================================

# regfile_32x32

MIPS general-purpose register file: 32 registers of 32 bits, one synchronous write port and two asynchronous read ports. The write side is a 5-to-32 one-hot decoder gating per-register write enables; the read side selects through mux_32to1 instances. It sits between the write-back stage (wa/wd/we) and the decode stage (rs/rt reads) of the datapath. Register $0 is hardwired to zero.

## Interface
- BYPASS, 0: 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- we  in  1  write enable, sampled at rising clk
- wa  in  5  write register address
- wd  in  32  write data
- ra1  in  5  read address, port 1 (rs)
- ra2  in  5  read address, port 2 (rt)
- rd1  out  32  read data, port 1, combinational
- rd2  out  32  read data, port 2, combinational

## Operation
- Storage: regs[1..31], each 32-bit flop with own enable; regs[0] not stored, constant 32'h0.
- Write decode: decoder_5to32 converts wa to one-hot sel[31:0]; register k loads wd at rising clk iff we && sel[k] && k != 0. Exactly one (or zero) register changes per cycle.
- Write to wa=0 with we=1: no state change, no side effect; rd of $0 stays 0.
- Reads: rdN = value of register raN, selected via mux_32to1 (i0 tied to 0, i1..i31 from regs). Pure combinational from raN and stored state.
- BYPASS=1: if we && wa==raN && wa!=0 && rst_n, rdN = wd (current-cycle data); otherwise stored value. Applied independently per port; both ports may forward the same write.
- BYPASS=0: a write becomes visible on rd only after the capturing clk edge.
- Reset (rst_n=0): all regs[1..31] cleared to 0 immediately, asynchronously, regardless of clk; writes ignored while rst_n=0; bypass suppressed, so rd1=rd2=0 throughout reset.
- Reset deassertion: first write accepted at the first rising clk with rst_n=1.
- No X propagation: wa/ra values are all legal (5-bit covers all 32).

## Timing
- Write latency: 1 clock (wd visible on rd at edge+combinational delay, BYPASS=0); 0 clocks with BYPASS=1.
- Read latency: combinational, no clock involvement.
- Simultaneous write and read of the same register, BYPASS=0: read returns old value until edge, new value after.
- Back-to-back writes to the same register: last one wins; each edge captures its own wd.
- Reset asserted mid-cycle with we=1: write discarded, register reads 0.
- Outputs after reset: rd1=0, rd2=0 for all ra.

## Structure
- Shared package/header: REG_COUNT=32, REG_AW=5, DATA_W=32, ZERO_REG=5'd0.
- Sub-module: decoder_5to32 (in lib/, inverse of mux_32to1): in [4:0] a, en; out [31:0] y one-hot, y=0 when en=0.
- Two mux_32to1 instances for the read ports; bypass comparator per port in top level.

## Test plan
- Reset: drive rst_n=0 after loading regs[5]=32'hDEADBEEF -> rd1(ra1=5)=0 immediately, before any clk edge.
- Write/read all: for k=1..31 write wd=k*32'h01010101, then read each on both ports -> rd equals written value; ra=0 -> 0.
- $0 write: we=1, wa=0, wd=32'hFFFFFFFF, clk -> rd1(ra1=0)=0, no other register changed.
- Same-cycle read of written reg, BYPASS=0: reg7=5, write wa=7 wd=9 -> rd1=5 before edge, 9 after; BYPASS=1 -> rd1=9 before edge.
- Dual port: ra1=3, ra2=31 with reg3=32'h12345678, reg31=32'h0000ABCD -> both outputs correct concurrently; ra1=ra2=31 -> both 32'h0000ABCD.
- we=0 guard: wa=10, wd=32'hCAFE0000, we=0 over 4 edges -> reg10 unchanged.

Source files
------------

// File: rtl/regfile_32x32_pkg.sv
// Shared sizing and helpers for the MIPS 32x32 register file.
// Register $0 is architectural zero and is never stored.
package regfile_32x32_pkg;
   localparam int          REG_COUNT = 32;
   localparam int          REG_AW    = 5;
   localparam int          DATA_W    = 32;
   localparam logic [4:0]  ZERO_REG  = 5'd0;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [REG_AW-1:0] addr_t;

   // A pending write is forwardable only if it targets a real register.
   function automatic logic fwd_hit(input logic we, input addr_t wa, input addr_t ra);
      return we && (wa == ra) && (wa != ZERO_REG);
   endfunction
endpackage

// File: rtl/regfile_32x32_lib.sv
// Decode/select primitives: 5-to-32 one-hot decoder and 32-to-1 word mux.
// Purely combinational, no flow control.
module decoder_5to32
   import regfile_32x32_pkg::*;
(
   input  logic                 en,
   input  addr_t                a,
   output logic [REG_COUNT-1:0] y
);
   logic [REG_COUNT-1:0] one;

   always_comb begin
      one = {{(REG_COUNT-1){1'b0}}, 1'b1};
      y   = en ? (one << a) : '0;
   end
endmodule

module mux_32to1
   import regfile_32x32_pkg::*;
(
   input  addr_t                          s,
   input  logic [REG_COUNT-1:0][DATA_W-1:0] i,
   output word_t                          y
);
   assign y = i[s];
endmodule

// File: rtl/regfile_32x32.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Write visible after the capturing edge (same cycle when BYPASS=1); no backpressure.
module regfile_32x32
   import regfile_32x32_pkg::*;
#(
   parameter bit BYPASS = 1'b0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   word_t                           regs_q [1:REG_COUNT-1];
   word_t                           regs_d [1:REG_COUNT-1];
   logic [REG_COUNT-1:0]            sel;
   logic [REG_COUNT-1:0][DATA_W-1:0] mux_in;
   word_t                           mux_rd1;
   word_t                           mux_rd2;
   logic                            unused_sel0;

   // Writes are gated off entirely while reset is held.
   decoder_5to32 u_wdec (
      .en (we & rst_n),
      .a  (wa),
      .y  (sel)
   );

   assign unused_sel0 = sel[0];

   always_comb begin
      for (int k = 1; k < REG_COUNT; k++) begin
         regs_d[k] = sel[k] ? wd : regs_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < REG_COUNT; k++) regs_q[k] <= '0;
      end else begin
         for (int k = 1; k < REG_COUNT; k++) regs_q[k] <= regs_d[k];
      end
   end

   always_comb begin
      mux_in[0] = '0;
      for (int k = 1; k < REG_COUNT; k++) begin
         mux_in[k] = regs_q[k];
      end
   end

   mux_32to1 u_rmux1 (
      .s (ra1),
      .i (mux_in),
      .y (mux_rd1)
   );

   mux_32to1 u_rmux2 (
      .s (ra2),
      .i (mux_in),
      .y (mux_rd2)
   );

   always_comb begin
      rd1 = mux_rd1;
      rd2 = mux_rd2;
      if (BYPASS && rst_n) begin
         if (fwd_hit(we, wa, ra1)) rd1 = wd;
         if (fwd_hit(we, wa, ra2)) rd2 = wd;
      end
   end
endmodule

// File: tb/tb_regfile_32x32.sv
// Directed plus random checks of regfile_32x32, with and without bypass, against an array model.
module tb_regfile_32x32;
   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

   int checks;
   int failures;
   logic [31:0] mdl [0:31];

   regfile_32x32 #(.BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb)
   );

   regfile_32x32 #(.BYPASS(1'b1)) u_dut_bp (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_bp), .rd2(rd2_bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single write through a full clock; model follows the architectural rule.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wa = a; wd = d;
      @(posedge clk);
      #1;
      we = 1'b0;
      if (a != 5'd0) mdl[a] = d;
   endtask

   task automatic read_both(input string tag, input logic [4:0] a1, input logic [4:0] a2);
      ra1 = a1; ra2 = a2;
      #1;
      chk({tag, "_nb_rd1"}, rd1_nb, mdl[a1]);
      chk({tag, "_nb_rd2"}, rd2_nb, mdl[a2]);
      chk({tag, "_bp_rd1"}, rd1_bp, mdl[a1]);
      chk({tag, "_bp_rd2"}, rd2_bp, mdl[a2]);
   endtask

   initial begin
      logic [31:0] exp1, exp2;
      checks = 0; failures = 0;
      for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
      we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

      // Reset state
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 32; k += 7) read_both("reset_state", 5'(k), 5'(31 - k));
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset clears a loaded register before any clock edge
      do_write(5'd5, 32'hDEADBEEF);
      read_both("load5", 5'd5, 5'd5);
      #2;
      rst_n = 1'b0;
      for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
      ra1 = 5'd5;
      #1;
      chk("async_reset_nb", rd1_nb, 32'h0);
      chk("async_reset_bp", rd1_bp, 32'h0);
      // Writes and forwarding suppressed while in reset
      we = 1'b1; wa = 5'd5; wd = 32'h11112222; ra2 = 5'd5;
      #1;
      chk("rst_bypass_suppressed", rd2_bp, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_write_ignored_nb", rd1_nb, 32'h0);
      chk("rst_write_ignored_bp", rd1_bp, 32'h0);
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Write every register, then read each on both ports
      for (int k = 1; k < 32; k++) do_write(5'(k), 32'(k) * 32'h01010101);
      for (int k = 0; k < 32; k++) read_both("all_regs", 5'(k), 5'(k));
      chk("k3_value", mdl[3], 32'h03030303);

      // Writing $0 has no effect anywhere
      do_write(5'd0, 32'hFFFFFFFF);
      ra1 = 5'd0;
      #1;
      chk("zero_reg_nb", rd1_nb, 32'h0);
      chk("zero_reg_bp", rd1_bp, 32'h0);
      for (int k = 1; k < 32; k++) read_both("after_zero_wr", 5'(k), 5'(32 - k));

      // Same-cycle read of register being written
      do_write(5'd7, 32'd5);
      @(negedge clk);
      we = 1'b1; wa = 5'd7; wd = 32'd9; ra1 = 5'd7; ra2 = 5'd7;
      #1;
      chk("pre_edge_nb", rd1_nb, 32'd5);
      chk("pre_edge_bp_rd1", rd1_bp, 32'd9);
      chk("pre_edge_bp_rd2", rd2_bp, 32'd9);
      @(posedge clk);
      #1;
      we = 1'b0;
      mdl[7] = 32'd9;
      chk("post_edge_nb", rd1_nb, 32'd9);
      chk("post_edge_bp", rd1_bp, 32'd9);

      // Dual port concurrent reads
      do_write(5'd3, 32'h12345678);
      do_write(5'd31, 32'h0000ABCD);
      ra1 = 5'd3; ra2 = 5'd31;
      #1;
      chk("dual_rd1", rd1_nb, 32'h12345678);
      chk("dual_rd2", rd2_nb, 32'h0000ABCD);
      ra1 = 5'd31;
      #1;
      chk("same_addr_rd1", rd1_nb, 32'h0000ABCD);
      chk("same_addr_rd2", rd2_nb, 32'h0000ABCD);

      // we=0 holds state across several edges
      @(negedge clk);
      we = 1'b0; wa = 5'd10; wd = 32'hCAFE0000;
      repeat (4) @(posedge clk);
      #1;
      read_both("we0_guard", 5'd10, 5'd10);

      // Back-to-back writes: last one wins
      do_write(5'd12, 32'hAAAA0001);
      do_write(5'd12, 32'hAAAA0002);
      read_both("back2back", 5'd12, 5'd11);

      // Random traffic checked before and after each edge
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         we  = 1'($urandom_range(0, 1));
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         ra1 = 5'($urandom_range(0, 31));
         ra2 = (n % 5 == 0) ? wa : 5'($urandom_range(0, 31));
         #1;
         exp1 = (we && wa == ra1 && wa != 5'd0) ? wd : mdl[ra1];
         exp2 = (we && wa == ra2 && wa != 5'd0) ? wd : mdl[ra2];
         chk("rnd_nb_rd1", rd1_nb, mdl[ra1]);
         chk("rnd_nb_rd2", rd2_nb, mdl[ra2]);
         chk("rnd_bp_rd1", rd1_bp, exp1);
         chk("rnd_bp_rd2", rd2_bp, exp2);
         @(posedge clk);
         if (we && wa != 5'd0) mdl[wa] = wd;
         #1;
         chk("rnd_post_nb_rd1", rd1_nb, mdl[ra1]);
         chk("rnd_post_nb_rd2", rd2_nb, mdl[ra2]);
      end
      we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
